// File: rtl/alu_pkg.sv
// Shared definitions for the serial ALU: aluop encodings and the control FSM state type.
package alu_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;
    localparam logic [2:0] OP_NOR = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } alu_state_t;

    // aluop[1] set selects the adder path (ADD, SUB, SLT).
    function automatic logic op_is_arith(input logic [2:0] op);
        return op[1];
    endfunction

    function automatic logic op_is_slt(input logic [2:0] op);
        return op[1:0] == 2'b11;
    endfunction

endpackage

// File: rtl/alu_slice.sv
// Combinational SLICE-bit ALU chunk with ripple carry; reused by serial_alu every cycle.
// SERIAL_ALU_NOR_EN makes aluop 3'b101 produce ~(a | b) instead of a | ~b.
module alu_slice
    import alu_pkg::*;
#(
    parameter int unsigned SLICE = 4
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    input  logic [2:0]       aluop,
    output logic [SLICE-1:0] out,
    output logic             cout,
    output logic             cmsb
);

    logic [SLICE-1:0] bx;
    logic [SLICE-1:0] sum;
    logic             carry;

    assign bx = b ^ {SLICE{aluop[2]}};

    always_comb begin
        carry = cin;
        cmsb  = 1'b0;
        sum   = '0;
        for (int i = 0; i < SLICE; i++) begin
            if (i == SLICE - 1) begin
                cmsb = carry;
            end
            sum[i] = a[i] ^ bx[i] ^ carry;
            carry  = (a[i] & bx[i]) | (carry & (a[i] ^ bx[i]));
        end
        cout = carry;
    end

    always_comb begin
        out = '0;
        unique case (aluop[1:0])
            2'b00: out = a & bx;
            2'b01: out = a | bx;
            2'b10: out = sum;
            2'b11: out = sum;
        endcase
`ifdef SERIAL_ALU_NOR_EN
        if (aluop == OP_NOR) begin
            out = ~(a | b);
        end
`endif
    end

endmodule

// File: rtl/serial_alu.sv
// Multi-cycle WIDTH-bit ALU processing SLICE bits per clock, LSB chunk first, with
// valid/ready on both sides. Optional MIPS NOR for aluop 3'b101 via SERIAL_ALU_NOR_EN.
module serial_alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       aluop,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             cout,
    output logic             zero
);

    localparam int unsigned N  = WIDTH / SLICE;
    localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;

    alu_state_t       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [2:0]       op_q, op_d;
    logic             carry_q, carry_d;
    logic [KW-1:0]    k_q, k_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             overflow_q, overflow_d;
    logic             cout_q, cout_d;
    logic             zero_q, zero_d;
    logic             out_valid_q, out_valid_d;

    logic [SLICE-1:0] slice_a, slice_b, slice_out;
    logic             slice_cout, slice_cmsb;
    logic             msb_ovf, set;

    assign slice_a = a_q[k_q * SLICE +: SLICE];
    assign slice_b = b_q[k_q * SLICE +: SLICE];

    alu_slice #(
        .SLICE (SLICE)
    ) u_slice (
        .a     (slice_a),
        .b     (slice_b),
        .cin   (carry_q),
        .aluop (op_q),
        .out   (slice_out),
        .cout  (slice_cout),
        .cmsb  (slice_cmsb)
    );

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        carry_d     = carry_q;
        k_d         = k_q;
        result_d    = result_q;
        overflow_d  = overflow_q;
        cout_d      = cout_q;
        zero_d      = zero_q;
        out_valid_d = out_valid_q;
        msb_ovf     = slice_cmsb ^ slice_cout;
        set         = msb_ovf ^ slice_out[SLICE-1];

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    op_d    = aluop;
                    carry_d = aluop[2];
                    k_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                result_d[k_q * SLICE +: SLICE] = slice_out;
                carry_d = slice_cout;
                k_d     = k_q + 1'b1;
                if (k_q == KW'(N - 1)) begin
                    cout_d     = op_is_arith(op_q) & slice_cout;
                    overflow_d = op_is_arith(op_q) & msb_ovf;
                    if (op_is_slt(op_q)) begin
                        result_d = {{(WIDTH - 1){1'b0}}, set};
                    end
                    zero_d      = (result_d == '0);
                    out_valid_d = 1'b1;
                    k_d         = '0;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            carry_q     <= 1'b0;
            k_q         <= '0;
            result_q    <= '0;
            overflow_q  <= 1'b0;
            cout_q      <= 1'b0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            carry_q     <= carry_d;
            k_q         <= k_d;
            result_q    <= result_d;
            overflow_q  <= overflow_d;
            cout_q      <= cout_d;
            zero_q      <= zero_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign overflow  = overflow_q;
    assign cout      = cout_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_serial_alu.sv
// Self-checking bench for serial_alu (WIDTH=32, SLICE=4): directed cases plus randomized
// operations against a plain-arithmetic reference model.
module tb_serial_alu;

    localparam int W   = 32;
    localparam int S   = 4;
    localparam int LAT = W / S;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [2:0]    aluop;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  result;
    logic          overflow;
    logic          cout;
    logic          zero;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    serial_alu #(
        .WIDTH (W),
        .SLICE (S)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .aluop     (aluop),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .overflow  (overflow),
        .cout      (cout),
        .zero      (zero)
    );

    // Reference: signed overflow from operand/result signs, SLT as a signed compare.
    function automatic void model(input logic [31:0] ma, input logic [31:0] mb,
                                  input logic [2:0] op, output logic [31:0] r,
                                  output logic ov, output logic co, output logic z);
        logic [32:0] s;
        r  = '0;
        ov = 1'b0;
        co = 1'b0;
        case (op)
            3'b000: r = ma & mb;
            3'b001: r = ma | mb;
            3'b100: r = ma & ~mb;
`ifdef SERIAL_ALU_NOR_EN
            3'b101: r = ~(ma | mb);
`else
            3'b101: r = ma | ~mb;
`endif
            3'b010: begin
                s  = {1'b0, ma} + {1'b0, mb};
                r  = s[31:0];
                co = s[32];
                ov = (ma[31] == mb[31]) && (r[31] != ma[31]);
            end
            default: begin
                s  = {1'b0, ma} + {1'b0, ~mb} + 33'd1;
                r  = s[31:0];
                co = s[32];
                ov = (ma[31] != mb[31]) && (r[31] != ma[31]);
                if (op == 3'b111) r = {31'b0, $signed(ma) < $signed(mb)};
            end
        endcase
        z = (r == 32'd0);
    endfunction

    task automatic do_op(input logic [31:0] ta, input logic [31:0] tb_, input logic [2:0] op,
                         input bit rel, output logic [31:0] r, output logic ov,
                         output logic co, output logic z, output int lat, output bit to);
        int guard = 0;
        to = 1'b0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!in_ready) to = 1'b1;
        a = ta; b = tb_; aluop = op; in_valid = 1'b1;
        @(posedge clk); #1;
        // Scramble inputs after accept; they must have no effect.
        in_valid = 1'b0; a = $urandom; b = $urandom; aluop = 3'($urandom);
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) to = 1'b1;
        r = result; ov = overflow; co = cout; z = zero;
        if (rel) begin
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; aluop = '0;
        #2;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        checks++;
        if ({out_valid, overflow, cout, zero} !== 4'b0000 || result !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b ov=%b c=%b z=%b r=%h expected all 0",
                     out_valid, overflow, cout, zero, result);
        end
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [31:0] va[9], vb[9], vr[9];
        logic [2:0]  vo[9];
        logic [3:0]  vf[9]; // {ov, co, z, unused}
        logic [31:0] r;
        logic        ov, co, z;
        int          lat;
        bit          to;
        va = '{32'd7, 32'h7FFFFFFF, 32'd5, 32'hFFFFFFFD, 32'h7FFFFFFF,
               32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0};
        vb = '{32'd5, 32'hFFFFFFFF, 32'd5, 32'd2, 32'h80000000,
               32'hFF00FF00, 32'hFF00FF00, 32'hFF00FF00, 32'hFF00FF00};
        vo = '{3'b010, 3'b110, 3'b110, 3'b111, 3'b111, 3'b000, 3'b001, 3'b101, 3'b100};
`ifdef SERIAL_ALU_NOR_EN
        vr = '{32'd12, 32'h80000000, 32'd0, 32'd1, 32'd0,
               32'hF000F000, 32'hFFF0FFF0, 32'h000F000F, 32'h00F000F0};
`else
        vr = '{32'd12, 32'h80000000, 32'd0, 32'd1, 32'd0,
               32'hF000F000, 32'hFFF0FFF0, 32'hF0FFF0FF, 32'h00F000F0};
`endif
        vf = '{4'b0000, 4'b1000, 4'b0110, 4'b0100, 4'b1010,
               4'b0000, 4'b0000, 4'b0000, 4'b0000};
        for (int i = 0; i < 9; i++) begin
            do_op(va[i], vb[i], vo[i], 1'b1, r, ov, co, z, lat, to);
            checks++;
            if (to || lat != LAT) begin
                errors++;
                $display("FAIL directed%0d_latency: got %0d timeout=%0b expected %0d",
                         i, lat, to, LAT);
            end
            checks++;
            if (r !== vr[i]) begin
                errors++; $display("FAIL directed%0d_result: got %h expected %h", i, r, vr[i]);
            end
            checks++;
            if ({ov, co, z} !== vf[i][3:1]) begin
                errors++;
                $display("FAIL directed%0d_flags: got ov/c/z=%b%b%b expected %b",
                         i, ov, co, z, vf[i][3:1]);
            end
        end
    endtask

    task automatic test_random();
        logic [2:0]  ops[7];
        logic [31:0] ta, tb_, r, er;
        logic [2:0]  op;
        logic        ov, co, z, eov, eco, ez;
        int          lat, sel;
        bit          to;
        ops = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111, 3'b100, 3'b101};
        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 3);
            ta  = $urandom;
            tb_ = (sel == 0) ? ta : (sel == 1) ? ~ta : $urandom;
            op  = ops[$urandom_range(0, 6)];
            model(ta, tb_, op, er, eov, eco, ez);
            do_op(ta, tb_, op, 1'b1, r, ov, co, z, lat, to);
            checks++;
            if (to || r !== er || {ov, co, z} !== {eov, eco, ez}) begin
                errors++;
                $display("FAIL random%0d op=%b a=%h b=%h: got r=%h ov/c/z=%b%b%b to=%0b expected r=%h ov/c/z=%b%b%b",
                         i, op, ta, tb_, r, ov, co, z, to, er, eov, eco, ez);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] r, er;
        logic        ov, co, z, eov, eco, ez;
        int          lat;
        bit          to;
        model(32'h12345678, 32'h0FEDCBA9, 3'b010, er, eov, eco, ez);
        do_op(32'h12345678, 32'h0FEDCBA9, 3'b010, 1'b0, r, ov, co, z, lat, to);
        checks++;
        if (to || r !== er) begin
            errors++; $display("FAIL bp_result: got %h timeout=%0b expected %h", r, to, er);
        end
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; a = $urandom; b = $urandom; aluop = 3'b010;
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || result !== er || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d: got v=%b r=%h rdy=%b expected v=1 r=%h rdy=0",
                         i, out_valid, result, in_ready, er);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: got v=%b rdy=%b expected v=0 rdy=1", out_valid, in_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r, er;
        logic        ov, co, z, eov, eco, ez;
        int          lat;
        bit          to;
        for (int i = 0; i < 3; i++) begin
            model(32'h80000000 + i, 32'h80000000, 3'b010, er, eov, eco, ez);
            do_op(32'h80000000 + i, 32'h80000000, 3'b010, 1'b1, r, ov, co, z, lat, to);
            checks++;
            if (to || lat != LAT || r !== er || {ov, co, z} !== {eov, eco, ez}) begin
                errors++;
                $display("FAIL b2b%0d: got r=%h ov/c/z=%b%b%b lat=%0d expected r=%h ov/c/z=%b%b%b lat=%0d",
                         i, r, ov, co, z, lat, er, eov, eco, ez, LAT);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] r;
        logic        ov, co, z;
        int          lat;
        bit          to;
        a = 32'hFFFFFFFF; b = 32'h0; aluop = 3'b010; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, overflow, cout, zero} !== 4'b0000 || result !== 32'd0 ||
            in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midreset_outputs: got v=%b ov=%b c=%b z=%b r=%h rdy=%b expected zeros rdy=1",
                     out_valid, overflow, cout, zero, result, in_ready);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        do_op(32'h00000FFF, 32'h00000001, 3'b010, 1'b1, r, ov, co, z, lat, to);
        checks++;
        if (to || lat != LAT || r !== 32'h00001000 || {ov, co, z} !== 3'b000) begin
            errors++;
            $display("FAIL midreset_next_add: got r=%h ov/c/z=%b%b%b lat=%0d expected r=00001000 ov/c/z=000 lat=%0d",
                     r, ov, co, z, lat, LAT);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
